mse_accumulator: RTL and testbench
==================================

# mse_accumulator

Streaming mean-squared-error metric stage placed directly downstream of the approximate-adder FIR filter. Each valid cycle it takes the approximate filter output and the exact-reference filter output, squares their difference, and accumulates over a window of 2^LOG2_N samples. The pipeline is three stages deep. At window end it publishes the sum of squared errors (SSE) and the MSE, and pulses `done`.

## Interface
- `DATA_W`, 16: sample width; both inputs are signed two's complement.
- `LOG2_N`, 10: window length is N = 2^LOG2_N counted samples.
- `SKIP`, 9: number of initial accepted samples discarded after `start`; covers FIR fill.
- `ACC_W`, 2*DATA_W+LOG2_N: SSE accumulator width (derived; never overridden).

- `clk` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new measurement window; honoured only in IDLE.
- `in_valid` in 1: `y_apx`/`y_ref` valid this cycle.
- `y_apx` in DATA_W: approximate FIR output, signed.
- `y_ref` in DATA_W: exact FIR output, signed.
- `busy` out 1: high from RUN through DONE.
- `done` out 1: one-cycle pulse; results are valid from this cycle onward.
- `sse` out ACC_W: sum of squared errors over the window, unsigned.
- `mse` out 2*DATA_W: sse >> LOG2_N, unsigned (truncating).
- `max_err` out DATA_W+1: largest |y_apx − y_ref| in the window, unsigned. Present only with MSE_MAXERR_EN.

## Operation
- **Reset:** all outputs are 0, FSM is IDLE, counters and pipeline are cleared. `rstN` low at any time, including mid-window, aborts immediately; there is no partial result.
- **FSM states:**
  - IDLE → RUN on `start`. The accumulator, skip counter and sample counter clear on that edge.
  - RUN → DRAIN when the N-th counted sample is accepted.
  - DRAIN lasts 2 cycles while the pipeline flushes, then → DONE.
  - DONE lasts 1 cycle: it registers `sse`/`mse`, pulses `done`, then → IDLE.
- **Accept rule:** a sample is accepted on an edge where the state is RUN and `in_valid` is 1. The first SKIP accepted samples are dropped; the next N are counted.
  - `in_valid` gaps are allowed; counting stalls.
  - `in_valid` outside RUN is ignored.
  - `start` and `in_valid` in the same IDLE cycle: that sample is not accepted.
- `start` while `busy` is ignored.
- **Pipeline:**
  - S1 computes d = y_apx − y_ref, sign-extended to DATA_W+1 bits (no overflow).
  - S2 computes sq = d*d as an unsigned 2*DATA_W value; the maximum of 65535² fits.
  - S3 does acc += sq. ACC_W guarantees no overflow; there is no saturation.
- Only counted samples propagate a valid bit through S1–S3. Dropped and idle cycles add 0.
- **Result hold:** `sse`, `mse` (and `max_err`) hold their values until the next DONE or reset. They do not change when a new `start` is accepted.

## Timing
- Let edge E0 be the edge that accepts the last counted sample.
  - S1 registers at E0, S2 at E1, S3 at E2.
  - `sse`/`mse` register at E3, and `done` is high for exactly the cycle after E3.
- `busy` rises the cycle after the `start` edge and falls the cycle after `done`. Earliest next `start` acceptance is the cycle `busy` is low.
- Minimum window time: SKIP+N accepting cycles, plus 3 cycles to `done`.
- Throughput is one sample per clock.

## Configuration
- **`MSE_MAXERR_EN` defined:**
  - An extra S2 register holds |d|.
  - A running maximum (DATA_W+1 bits) clears on `start` acceptance and updates on counted samples.
  - `max_err` registers alongside `sse` at E3.
- **`MSE_MAXERR_EN` undefined:** the `max_err` port, its logic and its registers are absent; all other behaviour is identical.

## Test plan
- **Zero error:** LOG2_N=4, SKIP=0, y_apx=y_ref=1234 for 16 cycles → `done` 3 cycles after the last sample; `sse`=0, `mse`=0, `max_err`=0.
- **Constant offset:** LOG2_N=4, SKIP=2, y_apx=y_ref+3 continuously → first 2 samples dropped; `sse`=144, `mse`=9, `max_err`=3.
- **Extreme difference:** LOG2_N=1, SKIP=0, y_apx=32767, y_ref=−32768 for 2 samples → `sse`=8589672450, `mse`=4294836225, `max_err`=65535.
- **Gaps and ignored controls:** `in_valid` toggling 1/0 with diff=−2; `start` pulsed mid-window; `in_valid` high before `start` → only 16 counted samples; `sse`=64, `mse`=4; the second `start` has no effect.
- **Reset mid-window:** `rstN` low after 7 counted samples → all outputs 0, `busy` 0, no `done`. Then a new `start` completes a full 16-sample window with a correct result.
- **Back-to-back windows:** diff=1 for window A, then `start` in the cycle after `busy` falls with diff=2 for window B → `mse`=1 is held during B, then becomes 4 at B's `done`.

Source files
------------

// File: rtl/mse_accumulator.sv
// Streaming mean-squared-error stage: squares (y_apx - y_ref) over a window of 2^LOG2_N counted samples.
// Optional running |error| maximum on the max_err port when MSE_MAXERR_EN is defined.
module mse_accumulator #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 10,
  parameter int SKIP   = 9
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            y_apx,
  input  logic [DATA_W-1:0]            y_ref,
  output logic                         busy,
  output logic                         done,
  output logic [2*DATA_W+LOG2_N-1:0]   sse,
  output logic [2*DATA_W-1:0]          mse
`ifdef MSE_MAXERR_EN
  ,output logic [DATA_W:0]             max_err
`endif
);

  localparam int ACC_W  = 2*DATA_W + LOG2_N;
  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                drain_q;
  logic                done_q;
  logic [SKIP_W-1:0]   skip_q;
  logic [LOG2_N-1:0]   cnt_q;

  logic                start_acc;
  logic                accept;
  logic                counted;
  logic                last;

  // Start is ignored during the done cycle too, since busy is still high there.
  assign start_acc = (state_q == S_IDLE) && start && !done_q;
  assign accept    = (state_q == S_RUN) && in_valid;
  assign counted   = accept && (skip_q == SKIP_W'(SKIP));
  assign last      = counted && (cnt_q == {LOG2_N{1'b1}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      skip_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == S_DRAIN) && !drain_q;
      done_q  <= (state_q == S_DONE);
      if (start_acc) begin
        skip_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (accept && !counted) skip_q <= skip_q + 1'b1;
        if (counted) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Pipeline: S1 difference, S2 square, S3 accumulate.
  logic [DATA_W:0]     d_q;
  logic                v1_q;
  logic [DATA_W:0]     abs_d;
  logic [2*DATA_W-1:0] abs_ext;
  logic [2*DATA_W-1:0] sq_d, sq_q;
  logic                v2_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sse_q;
  logic [2*DATA_W-1:0] mse_q;

  assign abs_d   = d_q[DATA_W] ? (~d_q + 1'b1) : d_q;
  assign abs_ext = {{(DATA_W-1){1'b0}}, abs_d};
  assign sq_d    = abs_ext * abs_ext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      d_q   <= '0;
      v1_q  <= 1'b0;
      sq_q  <= '0;
      v2_q  <= 1'b0;
      acc_q <= '0;
      sse_q <= '0;
      mse_q <= '0;
    end else begin
      d_q  <= {y_apx[DATA_W-1], y_apx} - {y_ref[DATA_W-1], y_ref};
      v1_q <= counted;
      sq_q <= sq_d;
      v2_q <= v1_q;
      if (start_acc) acc_q <= '0;
      else if (v2_q) acc_q <= acc_q + {{LOG2_N{1'b0}}, sq_q};
      if (state_q == S_DONE) begin
        sse_q <= acc_q;
        mse_q <= acc_q[ACC_W-1:LOG2_N];
      end
    end
  end

`ifdef MSE_MAXERR_EN
  logic [DATA_W:0] abs_q;
  logic [DATA_W:0] max_q;
  logic [DATA_W:0] max_err_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      abs_q     <= '0;
      max_q     <= '0;
      max_err_q <= '0;
    end else begin
      abs_q <= abs_d;
      if (start_acc) max_q <= '0;
      else if (v2_q && (abs_q > max_q)) max_q <= abs_q;
      if (state_q == S_DONE) max_err_q <= max_q;
    end
  end

  assign max_err = max_err_q;
`endif

  assign busy = (state_q != S_IDLE) || done_q;
  assign done = done_q;
  assign sse  = sse_q;
  assign mse  = mse_q;

endmodule

// File: tb/tb_mse_accumulator.sv
// Scoreboard bench for mse_accumulator: three instances (N=16/SKIP=0, N=16/SKIP=2, N=2/SKIP=0).
// Build with MSE_MAXERR_EN defined to also check max_err.
module tb_mse_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN;
  logic [2:0]        start_v;
  logic [2:0]        in_valid_v;
  logic [2:0][15:0]  y_apx_v;
  logic [2:0][15:0]  y_ref_v;
  logic [2:0]        busy_v;
  logic [2:0]        done_v;
  logic [35:0]       sse_a, sse_b;
  logic [32:0]       sse_c;
  logic [2:0][35:0]  sse_v;
  logic [2:0][31:0]  mse_v;
  logic [2:0][16:0]  maxe_v;

  assign sse_v[0] = sse_a;
  assign sse_v[1] = sse_b;
  assign sse_v[2] = {3'b000, sse_c};

  mse_accumulator #(.DATA_W(16), .LOG2_N(4), .SKIP(0)) u_a (
    .clk(clk), .rstN(rstN), .start(start_v[0]), .in_valid(in_valid_v[0]),
    .y_apx(y_apx_v[0]), .y_ref(y_ref_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sse(sse_a), .mse(mse_v[0])
`ifdef MSE_MAXERR_EN
    , .max_err(maxe_v[0])
`endif
  );

  mse_accumulator #(.DATA_W(16), .LOG2_N(4), .SKIP(2)) u_b (
    .clk(clk), .rstN(rstN), .start(start_v[1]), .in_valid(in_valid_v[1]),
    .y_apx(y_apx_v[1]), .y_ref(y_ref_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sse(sse_b), .mse(mse_v[1])
`ifdef MSE_MAXERR_EN
    , .max_err(maxe_v[1])
`endif
  );

  mse_accumulator #(.DATA_W(16), .LOG2_N(1), .SKIP(0)) u_c (
    .clk(clk), .rstN(rstN), .start(start_v[2]), .in_valid(in_valid_v[2]),
    .y_apx(y_apx_v[2]), .y_ref(y_ref_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .sse(sse_c), .mse(mse_v[2])
`ifdef MSE_MAXERR_EN
    , .max_err(maxe_v[2])
`endif
  );

`ifndef MSE_MAXERR_EN
  assign maxe_v = '0;
`endif

  typedef struct {
    int          inst;
    logic [35:0] sse;
    logic [31:0] mse;
    logic [16:0] maxe;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end
  endtask

  // Monitor: pops one expected result per observed done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rstN && done_v[i]) begin
        $display("done inst=%0d cyc=%0d sse=%0d mse=%0d max_err=%0d", i, cyc, sse_v[i], mse_v[i], maxe_v[i]);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(i), 64'(-1));
        end else begin
          e = sb_q.pop_front();
          check("done_inst", 64'(i), 64'(e.inst));
          check("sse", 64'(sse_v[i]), 64'(e.sse));
          check("mse", 64'(mse_v[i]), 64'(e.mse));
          check("done_latency_cycle", 64'(cyc), 64'(e.cyc));
`ifdef MSE_MAXERR_EN
          check("max_err", 64'(maxe_v[i]), 64'(e.maxe));
`endif
        end
      end
    end
  end

  task automatic run_window(input int k, input int n, input int apx, input int rf,
                            input bit gaps, input bit midstart, input bit prevalid,
                            input int abort_after, input logic [35:0] esse,
                            input logic [31:0] emse, input logic [16:0] emax,
                            input int hold_mse, input longint hold_sse);
    int   count;
    int   tog;
    int   t;
    bit   valid;
    exp_t e;
    if (prevalid) begin
      in_valid_v[k] = 1'b1;
      y_apx_v[k] = 16'(apx + 100);
      y_ref_v[k] = 16'(rf);
      repeat (3) @(negedge clk);
    end
    start_v[k]    = 1'b1;
    in_valid_v[k] = prevalid;
    y_apx_v[k]    = 16'(apx + 100);
    y_ref_v[k]    = 16'(rf);
    @(negedge clk);
    start_v[k] = 1'b0;
    count = 0;
    tog   = 0;
    while (count < n && !(abort_after > 0 && count == abort_after)) begin
      valid = !gaps || (tog % 2 == 0);
      in_valid_v[k] = valid;
      y_apx_v[k]    = valid ? 16'(apx) : 16'(apx + 50);
      y_ref_v[k]    = 16'(rf);
      start_v[k]    = midstart && valid && (count == 5);
      if (hold_mse >= 0 && valid && count == 8) begin
        check("hold_mse", 64'(mse_v[k]), 64'(hold_mse));
        check("hold_sse", 64'(sse_v[k]), 64'(hold_sse));
      end
      if (valid && count == n - 1) begin
        e.inst = k; e.sse = esse; e.mse = emse; e.maxe = emax; e.cyc = cyc + 4;
        sb_q.push_back(e);
      end
      if (valid) count++;
      tog++;
      @(negedge clk);
    end
    in_valid_v[k] = 1'b0;
    start_v[k]    = 1'b0;
    if (abort_after == 0) begin
      t = 0;
      while (busy_v[k] && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (busy_v[k]) check("busy_fall_timeout", 64'(busy_v[k]), 64'(0));
    end
  endtask

  initial begin
    rstN       = 1'b0;
    start_v    = '0;
    in_valid_v = '0;
    y_apx_v    = '0;
    y_ref_v    = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", 64'(busy_v[i]), 64'(0));
      check("reset_done", 64'(done_v[i]), 64'(0));
      check("reset_sse", 64'(sse_v[i]), 64'(0));
      check("reset_mse", 64'(mse_v[i]), 64'(0));
    end
    rstN = 1'b1;
    @(negedge clk);

    // Zero error; done latency checked by the scoreboard entry's cycle.
    run_window(0, 16, 1234, 1234, 0, 0, 0, 0, 36'd0, 32'd0, 17'd0, -1, -1);
    // Constant offset +3 with two dropped samples.
    run_window(1, 18, 1237, 1234, 0, 0, 0, 0, 36'd144, 32'd9, 17'd3, -1, -1);
    // Extreme difference on the N=2 instance.
    run_window(2, 2, 32767, -32768, 0, 0, 0, 0, 36'd8589672450, 32'd4294836225, 17'd65535, -1, -1);
    // Gaps, mid-window start, in_valid before start; diff = -2.
    run_window(0, 16, 98, 100, 1, 1, 1, 0, 36'd64, 32'd4, 17'd2, -1, -1);

    // Reset after 7 counted samples: results cleared, no done.
    run_window(0, 16, 10, 5, 0, 0, 0, 7, 36'd0, 32'd0, 17'd0, -1, -1);
    rstN = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy_v[0]), 64'(0));
    check("abort_done", 64'(done_v[0]), 64'(0));
    check("abort_sse", 64'(sse_v[0]), 64'(0));
    check("abort_mse", 64'(mse_v[0]), 64'(0));
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done_busy", 64'(busy_v[0]), 64'(0));
    run_window(0, 16, 10, 5, 0, 0, 0, 0, 36'd400, 32'd25, 17'd5, -1, -1);

    // Back-to-back: window B starts in the first cycle busy is low; A's result held during B.
    run_window(0, 16, 7, 6, 0, 0, 0, 0, 36'd16, 32'd1, 17'd1, -1, -1);
    run_window(0, 16, 8, 6, 0, 0, 0, 0, 36'd64, 32'd4, 17'd2, 1, 16);

    repeat (5) @(negedge clk);
    check("pending_done_count", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
